// File: rtl/led_rgb_pwm.sv
// led_rgb_pwm: PWM driver for N_LED common-anode RGB LEDs with a shared
// prescaled period counter and double-buffered per-channel duty registers.
// Optional fade mode (active ramps one step per period toward the written
// duty) is enabled by defining LED_RGB_PWM_FADE_EN.
module led_rgb_pwm #(
    parameter int unsigned N_LED      = 4,
    parameter int unsigned PWM_W      = 8,
    parameter int unsigned PRESC_W    = 8,
    parameter bit          ACTIVE_LOW = 1'b1,
    localparam int unsigned LED_W     = (N_LED > 1) ? $clog2(N_LED) : 1
) (
    input  logic                 fpga_sysclk,
    input  logic                 rst_fpga_,
    input  logic [PRESC_W-1:0]   presc,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [LED_W-1:0]     wr_led,
    input  logic [1:0]           wr_color,
    input  logic [PWM_W-1:0]     wr_duty,
    output logic                 wr_err,
    output logic                 frame,
    output logic [3*N_LED-1:0]   led_rgb
);

    localparam int unsigned      N_CH     = 3 * N_LED;
    localparam logic [PWM_W-1:0] CNT_LAST = PWM_W'((2 ** PWM_W) - 2);

    logic [PRESC_W-1:0] r_pc;
    logic [PWM_W-1:0]   r_cnt;
    logic [PWM_W-1:0]   r_shadow [N_CH];
    logic [PWM_W-1:0]   r_active [N_CH];
    logic               r_ready;
    logic               r_err;
    logic               r_frame;
    logic [N_CH-1:0]    r_led;

    logic               w_tick;
    logic               w_boundary;
    logic               w_accept;
    logic               w_bad_led;
    logic [N_CH-1:0]    w_wr_sel;
    logic [N_CH-1:0]    w_on;

    // A tick ends each prescaler interval; the last tick of a period is the boundary.
    assign w_tick     = (r_pc == presc);
    assign w_boundary = w_tick && (r_cnt == CNT_LAST);
    assign w_accept   = wr_valid && r_ready;
    assign w_bad_led  = (32'(wr_led) >= N_LED);

    // Decode an accepted write into per-channel shadow enables.
    always_comb begin
        w_wr_sel = '0;
        for (int unsigned i = 0; i < N_LED; i++) begin
            for (int unsigned c = 0; c < 3; c++) begin
                if (w_accept && !w_bad_led && (32'(wr_led) == i) &&
                    ((wr_color == 2'(c)) || (wr_color == 2'd3))) begin
                    w_wr_sel[3*i+c] = 1'b1;
                end
            end
        end
    end

    // Channel is lit while the period counter is below its active duty.
    always_comb begin
        w_on = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            w_on[k] = (r_cnt < r_active[k]);
        end
    end

    // Prescaler, period counter and frame pulse.
    always_ff @(posedge fpga_sysclk) begin
        if (!rst_fpga_) begin
            r_pc    <= '0;
            r_cnt   <= '0;
            r_frame <= 1'b0;
        end else begin
            r_frame <= w_boundary;
            if (w_tick) begin
                r_pc  <= '0;
                r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + PWM_W'(1);
            end else begin
                r_pc  <= r_pc + PRESC_W'(1);
            end
        end
    end

    // Write handshake and out-of-range index error pulse.
    always_ff @(posedge fpga_sysclk) begin
        if (!rst_fpga_) begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ready <= 1'b1;
            r_err   <= w_accept && w_bad_led;
        end
    end

    // Shadow takes writes any time; active is refreshed only at the boundary,
    // so a write landing on the boundary edge is seen one period later.
    always_ff @(posedge fpga_sysclk) begin
        if (!rst_fpga_) begin
            for (int unsigned k = 0; k < N_CH; k++) begin
                r_shadow[k] <= '0;
                r_active[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < N_CH; k++) begin
                if (w_boundary) begin
`ifdef LED_RGB_PWM_FADE_EN
                    if (r_active[k] < r_shadow[k]) begin
                        r_active[k] <= r_active[k] + PWM_W'(1);
                    end else if (r_active[k] > r_shadow[k]) begin
                        r_active[k] <= r_active[k] - PWM_W'(1);
                    end
`else
                    r_active[k] <= r_shadow[k];
`endif
                end
                if (w_wr_sel[k]) begin
                    r_shadow[k] <= wr_duty;
                end
            end
        end
    end

    // Registered pin drive with polarity applied.
    always_ff @(posedge fpga_sysclk) begin
        if (!rst_fpga_) begin
            r_led <= {N_CH{ACTIVE_LOW}};
        end else begin
            r_led <= w_on ^ {N_CH{ACTIVE_LOW}};
        end
    end

    assign wr_ready = r_ready;
    assign wr_err   = r_err;
    assign frame    = r_frame;
    assign led_rgb  = r_led;

endmodule

// File: tb/tb_led_rgb_pwm.sv
// tb_led_rgb_pwm: directed and randomized checks of led_rgb_pwm against a
// frame-level duty model (per-period on-time counts, frame spacing, reset).
// Model follows LED_RGB_PWM_FADE_EN when defined.
module tb_led_rgb_pwm;

    localparam int unsigned N_CH   = 12;
    localparam int unsigned PERIOD = 255;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  presc;
    logic        wr_valid;
    logic        wr_ready;
    logic [1:0]  wr_led;
    logic [1:0]  wr_color;
    logic [7:0]  wr_duty;
    logic        wr_err;
    logic        frame;
    logic [11:0] led_rgb;

    logic        b_valid;
    logic        b_ready;
    logic [1:0]  b_led;
    logic [1:0]  b_color;
    logic [7:0]  b_duty;
    logic        b_err;
    logic        b_frame;
    logic [8:0]  b_led_rgb;

    int n_assert = 0;
    int n_fail   = 0;
    int m_shadow [N_CH];
    int m_active [N_CH];
    int m_presc;

    always #5 clk = ~clk;

    led_rgb_pwm dut (
        .fpga_sysclk (clk),
        .rst_fpga_   (rst_n),
        .presc       (presc),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_led      (wr_led),
        .wr_color    (wr_color),
        .wr_duty     (wr_duty),
        .wr_err      (wr_err),
        .frame       (frame),
        .led_rgb     (led_rgb)
    );

    led_rgb_pwm #(.N_LED(3), .ACTIVE_LOW(1'b0)) dut3 (
        .fpga_sysclk (clk),
        .rst_fpga_   (rst_n),
        .presc       (presc),
        .wr_valid    (b_valid),
        .wr_ready    (b_ready),
        .wr_led      (b_led),
        .wr_color    (b_color),
        .wr_duty     (b_duty),
        .wr_err      (b_err),
        .frame       (b_frame),
        .led_rgb     (b_led_rgb)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Period boundary: each channel's lit duty follows its written duty.
    task automatic model_boundary();
        for (int k = 0; k < int'(N_CH); k++) begin
`ifdef LED_RGB_PWM_FADE_EN
            if (m_active[k] < m_shadow[k]) m_active[k]++;
            else if (m_active[k] > m_shadow[k]) m_active[k]--;
`else
            m_active[k] = m_shadow[k];
`endif
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < int'(N_CH); k++) begin
            m_shadow[k] = 0;
            m_active[k] = 0;
        end
    endtask

    // One clock; a frame seen after the edge means that edge was a boundary.
    task automatic step();
        @(posedge clk);
        #1;
        if (rst_n && frame) model_boundary();
    endtask

    task automatic do_write(input int led, input int color, input int duty);
        check("wr_ready", 32'(wr_ready), 32'd1);
        wr_valid = 1'b1;
        wr_led   = 2'(led);
        wr_color = 2'(color);
        wr_duty  = 8'(duty);
        step();
        wr_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (color == 3 || color == c) m_shadow[3*led+c] = duty;
        end
        check("wr_err_main", 32'(wr_err), 32'd0);
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        step();
        while (!frame && n < 1100) begin
            step();
            n++;
        end
        check("wait_frame", 32'(frame), 32'd1);
    endtask

    // Called right after a frame pulse: counts lit cycles per channel over one period.
    task automatic measure_period(input string tag);
        int exp_cnt [N_CH];
        int low_cnt [N_CH];
        bit seen_off [N_CH];
        int nonprefix;
        int early;
        int len;
        len = int'(PERIOD) * (m_presc + 1);
        nonprefix = 0;
        early = 0;
        for (int k = 0; k < int'(N_CH); k++) begin
            exp_cnt[k]  = m_active[k] * (m_presc + 1);
            low_cnt[k]  = 0;
            seen_off[k] = 1'b0;
        end
        for (int t = 0; t < len; t++) begin
            step();
            for (int k = 0; k < int'(N_CH); k++) begin
                if (led_rgb[k] == 1'b0) begin
                    low_cnt[k]++;
                    if (seen_off[k]) nonprefix++;
                end else begin
                    seen_off[k] = 1'b1;
                end
            end
            if (t < len - 1 && frame) early++;
        end
        check({tag, "_frame_end"}, 32'(frame), 32'd1);
        check({tag, "_frame_early"}, 32'(early), 32'd0);
        check({tag, "_prefix"}, 32'(nonprefix), 32'd0);
        for (int k = 0; k < int'(N_CH); k++) begin
            check($sformatf("%s_on%0d", tag, k), 32'(low_cnt[k]), 32'(exp_cnt[k]));
        end
    endtask

    initial begin
        int n;
        int nw;
        rst_n    = 1'b0;
        presc    = 8'd0;
        m_presc  = 0;
        wr_valid = 1'b0;
        wr_led   = 2'd0;
        wr_color = 2'd0;
        wr_duty  = 8'd0;
        b_valid  = 1'b0;
        b_led    = 2'd0;
        b_color  = 2'd0;
        b_duty   = 8'd0;
        model_reset();

        // Reset held three cycles.
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_led", 32'(led_rgb), 32'hFFF);
            check("rst_ready", 32'(wr_ready), 32'd0);
            check("rst_frame", 32'(frame), 32'd0);
            check("rst_err", 32'(wr_err), 32'd0);
            check("rst_led3", 32'(b_led_rgb), 32'h000);
        end
        rst_n = 1'b1;
        step();
        check("ready_after_rst", 32'(wr_ready), 32'd1);
        check("led_after_rst", 32'(led_rgb), 32'hFFF);

        // LED0 red at duty 64.
        do_write(0, 0, 64);
        wait_frame();
        measure_period("d64");

        // LED1 green extremes.
        do_write(1, 1, 255);
        wait_frame();
        measure_period("g255a");
        measure_period("g255b");
        do_write(1, 1, 0);
        wait_frame();
        measure_period("g0");

        // All three colours of LED2 at once.
        do_write(2, 3, 128);
        wait_frame();
        measure_period("all128");

        // Ramp from 0 to 4 over successive frames.
        do_write(3, 2, 4);
        wait_frame();
        for (int i = 0; i < 4; i++) measure_period($sformatf("fade%0d", i));

        // Slower prescaler, then a write landing on the boundary edge.
        presc   = 8'd3;
        m_presc = 3;
        measure_period("presc3");
        for (int i = 0; i < int'(PERIOD) * 4 - 1; i++) step();
        do_write(0, 0, 200);
        check("wb_on_boundary", 32'(frame), 32'd1);
        measure_period("wb_old");
        measure_period("wb_new");

        // Randomized writes and prescaler settings.
        for (int it = 0; it < 8; it++) begin
            nw = int'($urandom_range(1, 3));
            for (int w = 0; w < nw; w++) begin
                n = int'($urandom_range(0, 300));
                for (int g = 0; g < n; g++) step();
                do_write(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 255)));
            end
            wait_frame();
            m_presc = int'($urandom_range(0, 3));
            presc   = 8'(m_presc);
            measure_period($sformatf("rnd%0d", it));
        end

        // Reset in the middle of a period.
        for (int i = 0; i < 100; i++) step();
        rst_n = 1'b0;
        step();
        model_reset();
        check("midrst_led", 32'(led_rgb), 32'hFFF);
        check("midrst_ready", 32'(wr_ready), 32'd0);
        check("midrst_frame", 32'(frame), 32'd0);
        rst_n = 1'b1;
        n = 0;
        step();
        n++;
        check("midrst_ready_up", 32'(wr_ready), 32'd1);
        while (!frame && n < 1100) begin
            step();
            n++;
        end
        check("midrst_restart", 32'(n), 32'(int'(PERIOD) * (m_presc + 1)));
        measure_period("post_rst");

        // Three-LED instance: out-of-range index and a valid broadcast write.
        check("b_ready", 32'(b_ready), 32'd1);
        b_valid = 1'b1;
        b_led   = 2'd3;
        b_color = 2'd3;
        b_duty  = 8'd100;
        step();
        b_valid = 1'b0;
        check("b_err_pulse", 32'(b_err), 32'd1);
        step();
        check("b_err_clear", 32'(b_err), 32'd0);
        b_valid = 1'b1;
        b_led   = 2'd2;
        b_color = 2'd3;
        b_duty  = 8'd255;
        step();
        b_valid = 1'b0;
        check("b_err_valid", 32'(b_err), 32'd0);
        n = 0;
        step();
        while (!b_frame && n < 1100) begin
            step();
            n++;
        end
        check("b_wait_frame", 32'(b_frame), 32'd1);
        step();
        check("b_led_on", 32'(b_led_rgb), 32'h1C0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
